sync_level_qual: RTL
====================

// Module: sync_level_qual
//
// PURPOSE
//  Qualifies a single-bit status (e.g. PMA signal_ok, CDR lock) arriving via sync_2xdff dout.
//  Removes glitches/chatter with separate rise/fall persistence filters.
//  Outputs a stable level, one-cycle edge pulses and a saturating transition counter.
//  Sits between the 2-flop synchronizer and PCS control (block-lock/link-status logic), all on clk.
//
// PARAMETERS
//  ON_CYCLES   16  consecutive 1 samples required to assert level (>=1)
//  OFF_CYCLES  4   consecutive 0 samples required to deassert level (>=1)
//  CNT_W       8   width of transition counter (>=1)
//
// PORTS
//  clk         in   1      clock; all logic on posedge
//  rst_n       in   1      reset, asynchronous assert, active-low
//  din_sync    in   1      already-synchronized status bit (sync_2xdff dout)
//  cnt_clr     in   1      synchronous clear of toggle_cnt
//  level       out  1      qualified status level
//  rise_pls    out  1      one-cycle pulse when level goes 0->1
//  fall_pls    out  1      one-cycle pulse when level goes 1->0
//  qualifying  out  1      1 while in RISE_Q or FALL_Q
//  toggle_cnt  out  CNT_W  count of qualified transitions, saturating
//
// BEHAVIOUR
//  - Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
//  - Reset: state=LOW, qcnt=0, level=0, rise_pls=0, fall_pls=0, qualifying=0, toggle_cnt=0.
//  - All outputs registered; none depends combinationally on inputs.
//  - FSM (2-bit): LOW, RISE_Q, HIGH, FALL_Q; qcnt width = clog2(max(ON,OFF))+1.
//    LOW:    din=1 -> ON_CYCLES==1 ? HIGH (level<=1, rise_pls<=1) : RISE_Q, qcnt<=1. din=0 -> stay.
//    RISE_Q: din=1 -> qcnt==ON_CYCLES-1 ? HIGH, level<=1, rise_pls<=1, qcnt<=0 : qcnt++.
//            din=0 -> LOW, qcnt<=0, no pulse.
//    HIGH:   mirror of LOW using OFF_CYCLES/FALL_Q.
//    FALL_Q: din=0 -> qcnt==OFF_CYCLES-1 ? LOW, level<=0, fall_pls<=1, qcnt<=0 : qcnt++.
//            din=1 -> HIGH, qcnt<=0, no pulse.
//  - Latency: level changes on the edge that samples the Nth consecutive qualifying value.
//  - Pulses high exactly one cycle, coincident with first cycle of new level; never both high.
//  - qualifying = registered (next_state==RISE_Q || next_state==FALL_Q).
//  - toggle_cnt: +1 on each rise_pls/fall_pls event (counted when the pulse is registered).
//    Saturates at 2^CNT_W-1, no wrap.
//    cnt_clr alone -> 0. cnt_clr with same-cycle event -> 1 (event not lost).
//  - Interrupted qualification restarts from 0; no partial credit carried.
//  - Reset mid-qualification or in HIGH: immediate return to reset values.
//    After release, level=1 requires full ON_CYCLES even if din_sync held 1.
//  - Parameter values below minimum: elaboration error (generate-time check).
//
// STRUCTURE
//  - Shared package pcs25g_pkg: state encodings QST_LOW=2'd0, QST_RISE=2'd1, QST_HIGH=2'd2,
//    QST_FALL=2'd3; clog2 helper function.
//  - One sub-module: sat_cnt (WIDTH param; inc, clr inputs; clr+inc -> 1; saturating).
//  - Top holds FSM, qcnt and output registers. Parent instantiates sync_2xdff upstream.
//
// TESTING  (ON_CYCLES=4, OFF_CYCLES=2, CNT_W=3 unless noted)
//  1. Reset release with din_sync=1 held -> level=0 for 3 edges, level=1 and rise_pls=1 after 4th edge.
//  2. din_sync 1,1,1,0,1,1,1,1 -> no rise after first run; level=1 after 4th 1 of second run.
//  3. level=1, din_sync 0 for 1 cycle then 1 -> level stays 1, no fall_pls, qualifying high 1 cycle.
//  4. Nine full on/off cycles -> toggle_cnt saturates at 7; cnt_clr coincident with rise_pls -> 1.
//  5. rst_n asserted mid-RISE_Q (qcnt=2), asynchronously, no clock edge -> all outputs 0 immediately.
//  6. ON_CYCLES=1, OFF_CYCLES=1: toggle din_sync each cycle -> level follows din with 1-cycle latency;
//     rise_pls/fall_pls alternate every cycle.

Source files
------------

// File: rtl/pcs25g_pkg.sv
// Shared definitions for the 25G PCS status-qualification logic:
// qualifier state encodings and a ceiling-log2 helper.
package pcs25g_pkg;

  typedef enum logic [1:0] {
    QST_LOW  = 2'd0,
    QST_RISE = 2'd1,
    QST_HIGH = 2'd2,
    QST_FALL = 2'd3
  } qst_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear that coincides
// with an increment leaves the count at 1 so the event is not lost.
module sat_cnt
  import pcs25g_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;

  // Count register: clear wins over hold, increment stops at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= inc ? CNT_ONE : '0;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/sync_level_qual.sv
// Persistence filter for a synchronized status bit: separate rise/fall
// qualification windows, edge pulses and a saturating transition counter.
module sync_level_qual
  import pcs25g_pkg::*;
#(
  parameter int ON_CYCLES  = 16,
  parameter int OFF_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_sync,
  input  logic             cnt_clr,
  output logic             level,
  output logic             rise_pls,
  output logic             fall_pls,
  output logic             qualifying,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int QW   = clog2(MAXC) + 1;
  localparam logic [QW-1:0] Q_ONE    = QW'(1);
  localparam logic [QW-1:0] ON_LAST  = QW'(ON_CYCLES - 1);
  localparam logic [QW-1:0] OFF_LAST = QW'(OFF_CYCLES - 1);

  if (ON_CYCLES < 1) begin : g_bad_on
    $error("sync_level_qual: ON_CYCLES must be >= 1");
  end
  if (OFF_CYCLES < 1) begin : g_bad_off
    $error("sync_level_qual: OFF_CYCLES must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("sync_level_qual: CNT_W must be >= 1");
  end

  qst_e          r_state;
  logic [QW-1:0] r_qcnt;
  logic          r_level;
  logic          r_rise_pls;
  logic          r_fall_pls;
  logic          r_qualifying;
  logic          w_event;

  // Qualification FSM; pulses default low so they last exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= QST_LOW;
      r_qcnt       <= '0;
      r_level      <= 1'b0;
      r_rise_pls   <= 1'b0;
      r_fall_pls   <= 1'b0;
      r_qualifying <= 1'b0;
    end else begin
      r_rise_pls <= 1'b0;
      r_fall_pls <= 1'b0;
      case (r_state)
        QST_LOW: begin
          if (din_sync && (ON_CYCLES == 1)) begin
            r_state      <= QST_HIGH;
            r_level      <= 1'b1;
            r_rise_pls   <= 1'b1;
            r_qcnt       <= '0;
            r_qualifying <= 1'b0;
          end else if (din_sync) begin
            r_state      <= QST_RISE;
            r_qcnt       <= Q_ONE;
            r_qualifying <= 1'b1;
          end else begin
            r_qcnt       <= '0;
            r_qualifying <= 1'b0;
          end
        end
        QST_RISE: begin
          if (din_sync && (r_qcnt == ON_LAST)) begin
            r_state      <= QST_HIGH;
            r_level      <= 1'b1;
            r_rise_pls   <= 1'b1;
            r_qcnt       <= '0;
            r_qualifying <= 1'b0;
          end else if (din_sync) begin
            r_qcnt       <= r_qcnt + Q_ONE;
            r_qualifying <= 1'b1;
          end else begin
            r_state      <= QST_LOW;
            r_qcnt       <= '0;
            r_qualifying <= 1'b0;
          end
        end
        QST_HIGH: begin
          if (!din_sync && (OFF_CYCLES == 1)) begin
            r_state      <= QST_LOW;
            r_level      <= 1'b0;
            r_fall_pls   <= 1'b1;
            r_qcnt       <= '0;
            r_qualifying <= 1'b0;
          end else if (!din_sync) begin
            r_state      <= QST_FALL;
            r_qcnt       <= Q_ONE;
            r_qualifying <= 1'b1;
          end else begin
            r_qcnt       <= '0;
            r_qualifying <= 1'b0;
          end
        end
        QST_FALL: begin
          if (!din_sync && (r_qcnt == OFF_LAST)) begin
            r_state      <= QST_LOW;
            r_level      <= 1'b0;
            r_fall_pls   <= 1'b1;
            r_qcnt       <= '0;
            r_qualifying <= 1'b0;
          end else if (!din_sync) begin
            r_qcnt       <= r_qcnt + Q_ONE;
            r_qualifying <= 1'b1;
          end else begin
            r_state      <= QST_HIGH;
            r_qcnt       <= '0;
            r_qualifying <= 1'b0;
          end
        end
        default: begin
          r_state      <= QST_LOW;
          r_level      <= 1'b0;
          r_qcnt       <= '0;
          r_qualifying <= 1'b0;
        end
      endcase
    end
  end

  // Transitions are counted from the registered pulse, so a clear issued
  // while a pulse is visible still lets that transition count as 1
  assign w_event = r_rise_pls | r_fall_pls;

  sat_cnt #(
    .WIDTH (CNT_W)
  ) u_sat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_event),
    .clr   (cnt_clr),
    .cnt   (toggle_cnt)
  );

  assign level      = r_level;
  assign rise_pls   = r_rise_pls;
  assign fall_pls   = r_fall_pls;
  assign qualifying = r_qualifying;

endmodule
